store_data_align: RTL and testbench
===================================

# store_data_align

Store-path counterpart of the load extension stage: accepts SB/SH/SW requests from the MEM stage, moves the store data into the correct byte lanes, and generates per-byte write enables for the word-addressed Data Memory. A store that crosses a 32-bit word boundary is split into two sequential word writes by a small state machine. The block sits between the EX/MEM segment register and the Data Memory write port. It stalls the pipeline through `req_ready` while a store is in flight.

## Interface
- `WORD_ADDR_W`, default 30: width of the Data Memory word address, which is byte address [31:2].
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: a store request is present.
- `req_ready` output 1: the block can accept a request; high only in IDLE.
- `req_type` input 2: store type; 2'b00 SB, 2'b01 SH, 2'b10 SW, 2'b11 reserved.
- `req_addr` input 32: byte address.
- `req_data` input 32: register rs2 value; the low byte or halfword is used for SB and SH.
- `mem_valid` output 1: a write beat is presented to memory.
- `mem_ready` input 1: memory accepts the beat this cycle.
- `mem_addr` output WORD_ADDR_W: word address of the beat.
- `mem_we` output 4: byte-lane write enables; bit i enables bits [8i+7:8i].
- `mem_wdata` output 32: lane-aligned write data.
- `misalign_err` output 1: one-cycle pulse when a crossing store is rejected (only when the split feature is compiled out).

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. A beat completes when `mem_valid && mem_ready`.
- On acceptance, register the following, with off = req_addr[1:0]:
  - sh64 = {32'b0, masked data} << (8*off). The masked data is req_data with bytes outside the access size zeroed.
  - m8 = {4'b0, base} << off, where base is 0001 for SB, 0011 for SH, 1111 for SW.
  - word = req_addr[31:2].
- Low beat: `mem_addr`=word, `mem_we`=m8[3:0], `mem_wdata`=sh64[31:0].
- High beat: only when m8[7:4]≠0. `mem_addr`=word+1, which wraps modulo 2^WORD_ADDR_W, so 0x3FFFFFFF+1=0. `mem_we`=m8[7:4], `mem_wdata`=sh64[63:32].
- Lanes with `mem_we` bit 0 drive 0 on `mem_wdata`.
- SB never splits. SH splits only at off=3. SW splits at off=1, 2 or 3.
- A reserved `req_type` is accepted and produces no beat; the state stays IDLE.
- State machine:
  - IDLE: on accept with any enable set, go to LOW.
  - LOW: `mem_valid`=1. On completion, go to HIGH if the store is split, otherwise to IDLE.
  - HIGH: `mem_valid`=1. On completion, go to IDLE.
- Outputs are held stable while `mem_valid && !mem_ready`, for unbounded backpressure.
- In IDLE: `mem_valid`=0, `mem_we`=0.

## Timing
- Reset values: state IDLE; `req_ready`=1; `mem_valid`=0; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0; `misalign_err`=0.
- Latency:
  - A request accepted at edge N presents the low beat from cycle N+1.
  - The high beat is presented in the cycle after the low beat completes.
  - Minimum occupancy is 2 cycles for an unsplit store and 3 cycles for a split store.
- `req_ready` is combinational from the state only. It never depends on `req_valid` or `mem_ready`.
- There are no back-to-back accepts: the next request is accepted at the earliest in the cycle after the last beat completes.
- Reset asserted mid-operation aborts the store immediately. Any beat not yet completed is discarded, and no partial second beat is issued after reset.

## Configuration
- `STORE_MISALIGN_SPLIT_EN` defined: crossing stores are split into two beats as described above.
- `STORE_MISALIGN_SPLIT_EN` undefined: a crossing store, i.e. m8[7:4]≠0, is accepted and dropped.
  - No beat is issued and the state stays IDLE.
  - `misalign_err` pulses high for the one cycle after acceptance.
  - Non-crossing stores behave identically to the defined case.
  - The HIGH state and the second-beat logic are not built.

## Test plan
- Aligned SW, addr 0x00000100, data 0xDEADBEEF: one beat with addr 0x40, we 1111, wdata 0xDEADBEEF; `req_ready` high again two cycles after acceptance.
- SB, addr 0x00000102, data 0xFFFFFFAB: one beat with addr 0x40, we 0100, wdata 0x00AB0000.
- SW, addr 0x00000103, data 0x11223344, with the macro defined:
  - Beat 1: addr 0x40, we 1000, wdata 0x44000000.
  - Beat 2: addr 0x41, we 0111, wdata 0x00112233.
- SH, addr 0xFFFFFFFF, data 0x0000BEEF, with `mem_ready` held low for 3 cycles on each beat:
  - Beat 1: addr 0x3FFFFFFF, we 1000, wdata 0xEF000000, held stable during the stall.
  - Beat 2: addr 0x0, we 0001, wdata 0x000000BE.
- Same SW at 0x103 with the macro undefined: `misalign_err` is a single-cycle pulse, `mem_valid` never rises, and `req_ready` stays 1.
- Reset asserted during the HIGH beat of a split store: outputs return to their reset values asynchronously. After release, an SW to 0x200 issues a single beat with addr 0x80 and we 1111.

Source files
------------

// File: rtl/store_data_align.sv
// Store-path byte-lane alignment: places SB/SH/SW data in lanes and builds byte write enables.
// Define STORE_MISALIGN_SPLIT_EN to split word-crossing stores into two beats; else they are dropped.
module store_data_align #(
   parameter int unsigned WORD_ADDR_W = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [1:0]             req_type_i,
   input  logic [31:0]            req_addr_i,
   input  logic [31:0]            req_data_i,
   output logic                   mem_valid_o,
   input  logic                   mem_ready_i,
   output logic [WORD_ADDR_W-1:0] mem_addr_o,
   output logic [3:0]             mem_we_o,
   output logic [31:0]            mem_wdata_o,
   output logic                   misalign_err_o
);

`ifdef STORE_MISALIGN_SPLIT_EN
   typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;
`else
   typedef enum logic [1:0] {StIdle, StLow} state_e;
`endif

   state_e                 state_q;
   logic                   mem_valid_q;
   logic [WORD_ADDR_W-1:0] mem_addr_q;
   logic [3:0]             mem_we_q;
   logic [31:0]            mem_wdata_q;
   logic                   misalign_err_q;

   logic [1:0]             off;
   logic [3:0]             base_d;
   logic [31:0]            masked_d;
   logic [7:0]             m8_d;
   logic [WORD_ADDR_W-1:0] word_d;
   logic                   accept;
   logic                   start_d;
   logic                   cross_err_d;

   assign off    = req_addr_i[1:0];
   assign word_d = req_addr_i[WORD_ADDR_W+1:2];
   assign accept = req_valid_i && (state_q == StIdle);

   always_comb begin
      base_d   = 4'b0000;
      masked_d = 32'h0;
      case (req_type_i)
         2'b00:   begin base_d = 4'b0001; masked_d = {24'h0, req_data_i[7:0]};  end
         2'b01:   begin base_d = 4'b0011; masked_d = {16'h0, req_data_i[15:0]}; end
         2'b10:   begin base_d = 4'b1111; masked_d = req_data_i;                end
         default: ;
      endcase
   end

   assign m8_d = {4'b0000, base_d} << off;

`ifdef STORE_MISALIGN_SPLIT_EN
   logic [63:0] sh_d;
   logic [3:0]  hi_we_q;
   logic [31:0] hi_wdata_q;

   assign sh_d        = {32'h0, masked_d} << {off, 3'b000};
   assign start_d     = accept && (base_d != 4'b0000);
   assign cross_err_d = 1'b0;
`else
   logic [31:0] sh_d;

   // Lanes shifted past bit 31 belong to the dropped crossing case, so truncation is harmless.
   assign sh_d        = masked_d << {off, 3'b000};
   assign start_d     = accept && (base_d != 4'b0000) && (m8_d[7:4] == 4'b0000);
   assign cross_err_d = accept && (m8_d[7:4] != 4'b0000);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         mem_valid_q    <= 1'b0;
         mem_addr_q     <= '0;
         mem_we_q       <= 4'b0000;
         mem_wdata_q    <= 32'h0;
         misalign_err_q <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
         hi_we_q        <= 4'b0000;
         hi_wdata_q     <= 32'h0;
`endif
      end else begin
         misalign_err_q <= cross_err_d;
         case (state_q)
            StIdle: begin
               if (start_d) begin
                  state_q     <= StLow;
                  mem_valid_q <= 1'b1;
                  mem_addr_q  <= word_d;
                  mem_we_q    <= m8_d[3:0];
                  mem_wdata_q <= sh_d[31:0];
`ifdef STORE_MISALIGN_SPLIT_EN
                  hi_we_q     <= m8_d[7:4];
                  hi_wdata_q  <= sh_d[63:32];
`endif
               end
            end
            StLow: begin
               if (mem_ready_i) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                  if (hi_we_q != 4'b0000) begin
                     state_q     <= StHigh;
                     mem_addr_q  <= mem_addr_q + {{(WORD_ADDR_W-1){1'b0}}, 1'b1};
                     mem_we_q    <= hi_we_q;
                     mem_wdata_q <= hi_wdata_q;
                  end else begin
                     state_q     <= StIdle;
                     mem_valid_q <= 1'b0;
                     mem_we_q    <= 4'b0000;
                  end
`else
                  state_q     <= StIdle;
                  mem_valid_q <= 1'b0;
                  mem_we_q    <= 4'b0000;
`endif
               end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            StHigh: begin
               if (mem_ready_i) begin
                  state_q     <= StIdle;
                  mem_valid_q <= 1'b0;
                  mem_we_q    <= 4'b0000;
               end
            end
`endif
            default: begin
               state_q     <= StIdle;
               mem_valid_q <= 1'b0;
               mem_we_q    <= 4'b0000;
            end
         endcase
      end
   end

   assign req_ready_o    = (state_q == StIdle);
   assign mem_valid_o    = mem_valid_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_we_o       = mem_we_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign misalign_err_o = misalign_err_q;

endmodule

// File: tb/tb_store_data_align.sv
// Directed bench for store_data_align; split/drop behaviour follows STORE_MISALIGN_SPLIT_EN.
module tb_store_data_align;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [29:0] mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic        misalign_err;

   int n_checks = 0;
   int n_errors = 0;

   store_data_align #(.WORD_ADDR_W(30)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_type_i     (req_type),
      .req_addr_i     (req_addr),
      .req_data_i     (req_data),
      .mem_valid_o    (mem_valid),
      .mem_ready_i    (mem_ready),
      .mem_addr_o     (mem_addr),
      .mem_we_o       (mem_we),
      .mem_wdata_o    (mem_wdata),
      .misalign_err_o (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_type  = t;
      req_addr  = a;
      req_data  = d;
      check_eq("ready_before_accept", {63'h0, req_ready}, 64'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input logic [29:0] a, input logic [3:0] we,
                              input logic [31:0] d, input int stall);
      for (int i = 0; i <= stall; i++) begin
         mem_ready = (i == stall);
         check_eq({tag, "_valid"}, {63'h0, mem_valid}, 64'h1);
         check_eq({tag, "_ready"}, {63'h0, req_ready}, 64'h0);
         check_eq({tag, "_addr"}, {34'h0, mem_addr}, {34'h0, a});
         check_eq({tag, "_we"}, {60'h0, mem_we}, {60'h0, we});
         check_eq({tag, "_wdata"}, {32'h0, mem_wdata}, {32'h0, d});
         @(posedge clk);
         @(negedge clk);
      end
      mem_ready = 1'b0;
   endtask

   task automatic expect_idle(input string tag);
      check_eq({tag, "_ready"}, {63'h0, req_ready}, 64'h1);
      check_eq({tag, "_valid"}, {63'h0, mem_valid}, 64'h0);
      check_eq({tag, "_we"}, {60'h0, mem_we}, 64'h0);
      check_eq({tag, "_err"}, {63'h0, misalign_err}, 64'h0);
   endtask

   task automatic expect_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, {63'h0, req_ready}, 64'h1);
      check_eq({tag, "_valid"}, {63'h0, mem_valid}, 64'h0);
      check_eq({tag, "_we"}, {60'h0, mem_we}, 64'h0);
      check_eq({tag, "_addr"}, {34'h0, mem_addr}, 64'h0);
      check_eq({tag, "_wdata"}, {32'h0, mem_wdata}, 64'h0);
      check_eq({tag, "_err"}, {63'h0, misalign_err}, 64'h0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_type  = 2'b00;
      req_addr  = 32'h0;
      req_data  = 32'h0;
      mem_ready = 1'b0;
      #12;
      expect_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
      expect_beat("sw_aligned", 30'h40, 4'b1111, 32'hDEAD_BEEF, 0);
      expect_idle("sw_aligned_done");

      issue(2'b00, 32'h0000_0102, 32'hFFFF_FFAB);
      expect_beat("sb_lane2", 30'h40, 4'b0100, 32'h00AB_0000, 0);
      expect_idle("sb_done");

      issue(2'b01, 32'h0000_0102, 32'h1234_CAFE);
      expect_beat("sh_upper", 30'h40, 4'b1100, 32'hCAFE_0000, 1);
      expect_idle("sh_done");

      issue(2'b11, 32'h0000_0100, 32'h5555_5555);
      expect_idle("reserved");
      @(posedge clk);
      @(negedge clk);
      expect_idle("reserved_next");

`ifdef STORE_MISALIGN_SPLIT_EN
      issue(2'b10, 32'h0000_0103, 32'h1122_3344);
      expect_beat("sw_split_lo", 30'h40, 4'b1000, 32'h4400_0000, 0);
      expect_beat("sw_split_hi", 30'h41, 4'b0111, 32'h0011_2233, 0);
      expect_idle("sw_split_done");

      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF);
      expect_beat("sh_wrap_lo", 30'h3FFF_FFFF, 4'b1000, 32'hEF00_0000, 3);
      expect_beat("sh_wrap_hi", 30'h0, 4'b0001, 32'h0000_00BE, 3);
      expect_idle("sh_wrap_done");

      // Abort during the second beat.
      issue(2'b10, 32'h0000_0103, 32'h1122_3344);
      expect_beat("abort_lo", 30'h40, 4'b1000, 32'h4400_0000, 0);
      check_eq("abort_in_high", {63'h0, mem_valid}, 64'h1);
      rst = 1'b1;
      #1;
      expect_reset_outputs("abort_async");
`else
      issue(2'b10, 32'h0000_0103, 32'h1122_3344);
      check_eq("drop_err_pulse", {63'h0, misalign_err}, 64'h1);
      check_eq("drop_valid", {63'h0, mem_valid}, 64'h0);
      check_eq("drop_ready", {63'h0, req_ready}, 64'h1);
      @(posedge clk);
      @(negedge clk);
      expect_idle("drop_after");

      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF);
      check_eq("drop_sh_err", {63'h0, misalign_err}, 64'h1);
      check_eq("drop_sh_valid", {63'h0, mem_valid}, 64'h0);
      @(posedge clk);
      @(negedge clk);
      expect_idle("drop_sh_after");

      // Abort during a stalled single beat.
      issue(2'b10, 32'h0000_0100, 32'hA5A5_A5A5);
      check_eq("abort_in_low", {63'h0, mem_valid}, 64'h1);
      rst = 1'b1;
      #1;
      expect_reset_outputs("abort_async");
`endif
      @(posedge clk);
      #1;
      check_eq("abort_held_valid", {63'h0, mem_valid}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expect_idle("post_reset");

      issue(2'b10, 32'h0000_0200, 32'hCAFE_F00D);
      expect_beat("sw_after_reset", 30'h80, 4'b1111, 32'hCAFE_F00D, 0);
      expect_idle("sw_after_reset_done");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
